rx_timestamp_latency_probe: RTL

- Receive-side counterpart of the radio RX timestamp stamper.
- The stamper replaces the first sample of timed data packets with vita_time[31:0]; this block sits on the host-bound sample stream (after axi_wrapper m_axis, before the consumer) and recovers those stamps.
- For each stamp it computes loopback latency against the local VITA time and accumulates last/min/max/sum/count statistics.
- Results are exposed over the settings/readback bus; the sample stream passes through unmodified.

---
 rtl/rx_timestamp_latency_probe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rx_timestamp_latency_probe.sv
// rx_timestamp_latency_probe
//
// Sits on the host-bound sample stream and recovers the vita_time[31:0] stamps
// that the RX stamper wrote into the first beat of timed packets. For each stamp
// it computes the loopback latency (local time minus stamp, modulo 2^32) and
// keeps last/min/max/sum/count statistics plus a sticky over-threshold flag.
// The sample stream passes through combinationally and is never altered.
//
// Ports:
//   clk, reset_n                 radio clock, asynchronous active-low reset
//   vita_time[63:0]              local VITA time (low 32 bits used)
//   i_t* / o_t*                  AXI-stream sample path in / out (passthrough)
//   set_stb/set_addr/set_data    settings bus (CTRL at SR_BASE, THRESH at +1)
//   rb_addr/rb_stb/rb_data       readback bus (registered, RB_BASE..RB_BASE+4)
//   over_thresh                  sticky: some latency exceeded THRESH
module rx_timestamp_latency_probe #(
  parameter logic [7:0] SR_BASE    = 8'd160,
  parameter logic [7:0] RB_BASE    = 8'd32,
  parameter logic [3:0] STAMP_TYPE = 4'b0010
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [63:0]  vita_time,
  input  logic [31:0]  i_tdata,
  input  logic [127:0] i_tuser,
  input  logic         i_tlast,
  input  logic         i_tvalid,
  output logic         i_tready,
  output logic [31:0]  o_tdata,
  output logic [127:0] o_tuser,
  output logic         o_tlast,
  output logic         o_tvalid,
  input  logic         o_tready,
  input  logic         set_stb,
  input  logic [7:0]   set_addr,
  input  logic [31:0]  set_data,
  input  logic [7:0]   rb_addr,
  output logic         rb_stb,
  output logic [63:0]  rb_data,
  output logic         over_thresh
);

  // Stream passthrough: zero latency, no modification.
  assign o_tdata  = i_tdata;
  assign o_tuser  = i_tuser;
  assign o_tlast  = i_tlast;
  assign o_tvalid = i_tvalid;
  assign i_tready = o_tready;

  logic        r_sop;
  logic        r_enable;
  logic [31:0] r_thresh;
  logic        r_v1;
  logic        r_v2;
  logic [31:0] r_stamp;
  logic [31:0] r_now;
  logic [31:0] r_lat;
  logic [31:0] r_last;
  logic [31:0] r_min;
  logic [31:0] r_max;
  logic [47:0] r_sum;
  logic [31:0] r_count;
  logic        r_over;
  logic [7:0]  r_rb_addr;
  logic        r_rb_stb;
  logic [63:0] r_rb_data;

  logic        w_hs;
  logic        w_stamp;
  logic        w_ctrl_wr;
  logic        w_thr_wr;
  logic        w_clear;
  logic [48:0] w_sum_ext;
  logic [7:0]  w_rb_off;
  logic [63:0] w_rb_next;
  logic        w_unused;

  assign w_unused  = ^vita_time[63:32];

  assign w_hs      = i_tvalid & o_tready;
  assign w_stamp   = w_hs & r_sop & r_enable & (i_tuser[127:124] == STAMP_TYPE);
  assign w_ctrl_wr = set_stb & (set_addr == SR_BASE);
  assign w_thr_wr  = set_stb & (set_addr == SR_BASE + 8'd1);
  assign w_clear   = w_ctrl_wr & set_data[1];
  // One extra bit catches the carry used for sum saturation.
  assign w_sum_ext = {1'b0, r_sum} + {17'd0, r_lat};
  assign w_rb_off  = rb_addr - RB_BASE;

  // Packet boundary tracking: the beat after a tlast handshake starts a packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sop <= 1'b1;
    end else if (w_hs) begin
      r_sop <= i_tlast;
    end
  end

  // Settings registers; clear is a pulse, not stored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable <= 1'b0;
      r_thresh <= 32'hFFFF_FFFF;
    end else begin
      if (w_ctrl_wr) r_enable <= set_data[0];
      if (w_thr_wr)  r_thresh <= set_data;
    end
  end

  // Stage 1 captures stamp and local time, stage 2 forms the modular latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_stamp <= '0;
      r_now   <= '0;
      r_lat   <= '0;
    end else begin
      r_v1 <= w_stamp & ~w_clear;
      r_v2 <= r_v1 & ~w_clear;
      if (w_stamp) begin
        r_stamp <= i_tdata;
        r_now   <= vita_time[31:0];
      end
      if (r_v1) r_lat <= r_now - r_stamp;
    end
  end

  // Stage 3: statistics. Clear takes priority over a coincident update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last  <= '0;
      r_min   <= 32'hFFFF_FFFF;
      r_max   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_over  <= 1'b0;
    end else if (w_clear) begin
      r_last  <= '0;
      r_min   <= 32'hFFFF_FFFF;
      r_max   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_over  <= 1'b0;
    end else if (r_v2) begin
      r_last <= r_lat;
      if ((r_count == '0) || (r_lat < r_min)) r_min <= r_lat;
      if (r_lat > r_max) r_max <= r_lat;
      r_sum <= w_sum_ext[48] ? 48'hFFFF_FFFF_FFFF : w_sum_ext[47:0];
      if (r_count != 32'hFFFF_FFFF) r_count <= r_count + 32'd1;
      if (r_lat > r_thresh) r_over <= 1'b1;
    end
  end

  always_comb begin
    w_rb_next = '0;
    case (w_rb_off)
      8'd0:    w_rb_next = {32'h0, r_last};
      8'd1:    w_rb_next = {r_max, r_min};
      8'd2:    w_rb_next = {16'h0, r_sum};
      8'd3:    w_rb_next = {31'h0, r_over, r_count};
      8'd4:    w_rb_next = {31'h0, r_enable, r_thresh};
      default: w_rb_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rb_addr <= '0;
      r_rb_stb  <= 1'b0;
      r_rb_data <= '0;
    end else begin
      r_rb_addr <= rb_addr;
      r_rb_stb  <= (rb_addr != r_rb_addr) | set_stb;
      r_rb_data <= w_rb_next;
    end
  end

  assign rb_stb      = r_rb_stb;
  assign rb_data     = r_rb_data;
  assign over_thresh = r_over;

endmodule
